// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional bubble counter port enabled by defining ID_EX_BUBBLE_COUNT_EN.
module etapa_id_ex #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned RBITS     = 5,
    parameter int unsigned ALUOPBITS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_Hold,
    input  logic                 i_Flush,
    input  logic [NBITS-1:0]     i_Registro1,
    input  logic [NBITS-1:0]     i_Registro2,
    input  logic [NBITS-1:0]     i_ExtensionData,
    input  logic [RBITS-1:0]     i_Rs,
    input  logic [RBITS-1:0]     i_Rt,
    input  logic [RBITS-1:0]     i_Rd,
    input  logic                 i_ALUSrc,
    input  logic                 i_RegDst,
    input  logic                 i_MemRead,
    input  logic                 i_MemWrite,
    input  logic                 i_MemtoReg,
    input  logic                 i_RegWrite,
    input  logic [ALUOPBITS-1:0] i_ALUOp,
    output logic [NBITS-1:0]     o_Registro1,
    output logic [NBITS-1:0]     o_Registro2,
    output logic [NBITS-1:0]     o_ExtensionData,
    output logic [RBITS-1:0]     o_Rs,
    output logic [RBITS-1:0]     o_Rt,
    output logic [RBITS-1:0]     o_Rd,
    output logic                 o_ALUSrc,
    output logic                 o_RegDst,
    output logic                 o_MemRead,
    output logic                 o_MemWrite,
    output logic                 o_MemtoReg,
    output logic                 o_RegWrite,
    output logic [ALUOPBITS-1:0] o_ALUOp,
`ifdef ID_EX_BUBBLE_COUNT_EN
    output logic [15:0]          o_BubbleCount,
`endif
    output logic                 o_Valid,
    output logic                 o_Stall
);

    typedef struct packed {
        logic [NBITS-1:0]     reg1;
        logic [NBITS-1:0]     reg2;
        logic [NBITS-1:0]     ext;
        logic [RBITS-1:0]     rs;
        logic [RBITS-1:0]     rt;
        logic [RBITS-1:0]     rd;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic [ALUOPBITS-1:0] alu_op;
        logic                 valid;
    } entry_t;

    entry_t entry_q, entry_d, entry_in;
    logic   stall;

    always_comb begin
        entry_in            = '0;
        entry_in.reg1       = i_Registro1;
        entry_in.reg2       = i_Registro2;
        entry_in.ext        = i_ExtensionData;
        entry_in.rs         = i_Rs;
        entry_in.rt         = i_Rt;
        entry_in.rd         = i_Rd;
        entry_in.alu_src    = i_ALUSrc;
        entry_in.reg_dst    = i_RegDst;
        entry_in.mem_read   = i_MemRead;
        entry_in.mem_write  = i_MemWrite;
        entry_in.mem_to_reg = i_MemtoReg;
        entry_in.reg_write  = i_RegWrite;
        entry_in.alu_op     = i_ALUOp;
        entry_in.valid      = 1'b1;
    end

    // Load in EX whose destination is read by the instruction in ID; $zero never hazards.
    always_comb begin
        stall = 1'b0;
        if (!i_Flush && entry_q.valid && entry_q.mem_read && (entry_q.rt != '0) &&
            ((entry_q.rt == i_Rs) || (entry_q.rt == i_Rt))) begin
            stall = 1'b1;
        end
    end

    always_comb begin
        entry_d = entry_in;
        if (i_Flush) begin
            entry_d = '0;
        end else if (i_Hold) begin
            entry_d = entry_q;
        end else if (stall) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble_load;

    // Flush outranks hold, so a flushed edge counts even while held.
    assign bubble_load = i_Flush || (!i_Hold && stall);

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_BubbleCount = bubble_cnt_q;
`endif

    assign o_Registro1     = entry_q.reg1;
    assign o_Registro2     = entry_q.reg2;
    assign o_ExtensionData = entry_q.ext;
    assign o_Rs            = entry_q.rs;
    assign o_Rt            = entry_q.rt;
    assign o_Rd            = entry_q.rd;
    assign o_ALUSrc        = entry_q.alu_src;
    assign o_RegDst        = entry_q.reg_dst;
    assign o_MemRead       = entry_q.mem_read;
    assign o_MemWrite      = entry_q.mem_write;
    assign o_MemtoReg      = entry_q.mem_to_reg;
    assign o_RegWrite      = entry_q.reg_write;
    assign o_ALUOp         = entry_q.alu_op;
    assign o_Valid         = entry_q.valid;
    assign o_Stall         = stall;

endmodule

// File: tb/tb_etapa_id_ex.sv
// Directed self-checking bench for etapa_id_ex (ID_EX_BUBBLE_COUNT_EN checks are conditional).
module tb_etapa_id_ex;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, flush;
    logic [31:0] reg1, reg2, ext;
    logic [4:0]  rs, rt, rd;
    logic        alu_src, reg_dst, mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0]  alu_op;

    logic [31:0] o_reg1, o_reg2, o_ext;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_alu_src, o_reg_dst, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
    logic [2:0]  o_alu_op;
    logic        o_valid, o_stall;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [15:0] o_bcnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    etapa_id_ex dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_Hold          (hold),
        .i_Flush         (flush),
        .i_Registro1     (reg1),
        .i_Registro2     (reg2),
        .i_ExtensionData (ext),
        .i_Rs            (rs),
        .i_Rt            (rt),
        .i_Rd            (rd),
        .i_ALUSrc        (alu_src),
        .i_RegDst        (reg_dst),
        .i_MemRead       (mem_read),
        .i_MemWrite      (mem_write),
        .i_MemtoReg      (mem_to_reg),
        .i_RegWrite      (reg_write),
        .i_ALUOp         (alu_op),
        .o_Registro1     (o_reg1),
        .o_Registro2     (o_reg2),
        .o_ExtensionData (o_ext),
        .o_Rs            (o_rs),
        .o_Rt            (o_rt),
        .o_Rd            (o_rd),
        .o_ALUSrc        (o_alu_src),
        .o_RegDst        (o_reg_dst),
        .o_MemRead       (o_mem_read),
        .o_MemWrite      (o_mem_write),
        .o_MemtoReg      (o_mem_to_reg),
        .o_RegWrite      (o_reg_write),
        .o_ALUOp         (o_alu_op),
`ifdef ID_EX_BUBBLE_COUNT_EN
        .o_BubbleCount   (o_bcnt),
`endif
        .o_Valid         (o_valid),
        .o_Stall         (o_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_id();
        hold = 0; flush = 0;
        reg1 = 0; reg2 = 0; ext = 0; rs = 0; rt = 0; rd = 0;
        alu_src = 0; reg_dst = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
        alu_op = 0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lw(input logic [4:0] dst);
        clr_id();
        rs = 5'd2; rt = dst; mem_read = 1; mem_to_reg = 1; reg_write = 1; alu_src = 1;
        ext = 32'h10;
    endtask

    initial begin
        clr_id();
        rst_n = 0;
        #1;
        chk("reset_valid", {31'b0, o_valid}, 0);
        chk("reset_stall", {31'b0, o_stall}, 0);
        chk("reset_reg1", o_reg1, 0);
        step();
        step();
        chk("reset_held_rs", {27'b0, o_rs}, 0);
        #2 rst_n = 1;

        // Normal flow
        rs = 5'd3; reg1 = 32'h0000_1234; alu_src = 1; alu_op = 3'd5;
        step();
        chk("norm_rs", {27'b0, o_rs}, 3);
        chk("norm_reg1", o_reg1, 32'h1234);
        chk("norm_alusrc", {31'b0, o_alu_src}, 1);
        chk("norm_aluop", {29'b0, o_alu_op}, 5);
        chk("norm_valid", {31'b0, o_valid}, 1);

        // Load-use: lw rt=8 in EX, consumer rs=8 in ID
        drive_lw(5'd8);
        step();
        clr_id();
        rs = 5'd8; rt = 5'd9; rd = 5'd10; reg1 = 32'hAAAA; reg_write = 1;
        #1;
        chk("lu_stall", {31'b0, o_stall}, 1);
        step();
        chk("lu_bubble_valid", {31'b0, o_valid}, 0);
        chk("lu_bubble_regwrite", {31'b0, o_reg_write}, 0);
        chk("lu_bubble_memread", {31'b0, o_mem_read}, 0);
        chk("lu_after_stall", {31'b0, o_stall}, 0);
        step();
        chk("lu_capture_rs", {27'b0, o_rs}, 8);
        chk("lu_capture_reg1", o_reg1, 32'hAAAA);
        chk("lu_capture_valid", {31'b0, o_valid}, 1);

        // Load-use on rt match
        drive_lw(5'd11);
        step();
        clr_id();
        rs = 5'd1; rt = 5'd11;
        #1;
        chk("lu_rt_stall", {31'b0, o_stall}, 1);

        // Zero register never stalls
        drive_lw(5'd0);
        step();
        clr_id();
        rs = 5'd0; rt = 5'd0; rd = 5'd5;
        #1;
        chk("zero_stall", {31'b0, o_stall}, 0);
        step();
        chk("zero_load_rd", {27'b0, o_rd}, 5);
        chk("zero_load_valid", {31'b0, o_valid}, 1);

        // Flush beats hold and a pending load-use
        drive_lw(5'd7);
        step();
        clr_id();
        rs = 5'd7;
        #1;
        chk("prio_pre_stall", {31'b0, o_stall}, 1);
        flush = 1; hold = 1;
        #1;
        chk("prio_flush_stall", {31'b0, o_stall}, 0);
        step();
        chk("prio_valid", {31'b0, o_valid}, 0);
        chk("prio_rt", {27'b0, o_rt}, 0);
        chk("prio_memread", {31'b0, o_mem_read}, 0);
        clr_id();

        // Hold for three cycles while inputs change
        rd = 5'd12; reg2 = 32'h55; reg_write = 1;
        step();
        chk("hold_pre_rd", {27'b0, o_rd}, 12);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            rd = 5'(13 + i); reg2 = 32'h66 + i;
            step();
            chk("hold_rd", {27'b0, o_rd}, 12);
            chk("hold_reg2", o_reg2, 32'h55);
        end
        hold = 0;
        step();
        chk("hold_release_rd", {27'b0, o_rd}, 15);
        chk("hold_release_reg2", o_reg2, 32'h68);

        // Hold keeps the stall visible and defers the bubble
        drive_lw(5'd4);
        step();
        clr_id();
        rs = 5'd4; hold = 1;
        step();
        chk("holdstall_memread", {31'b0, o_mem_read}, 1);
        chk("holdstall_stall", {31'b0, o_stall}, 1);
        hold = 0;
        step();
        chk("holdstall_bubble", {31'b0, o_valid}, 0);

        // Reset mid-stall clears state asynchronously
        drive_lw(5'd6);
        step();
        clr_id();
        rs = 5'd6;
        #1;
        chk("rst_pre_stall", {31'b0, o_stall}, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_async_valid", {31'b0, o_valid}, 0);
        chk("rst_async_stall", {31'b0, o_stall}, 0);
        chk("rst_async_rt", {27'b0, o_rt}, 0);
        chk("rst_async_memread", {31'b0, o_mem_read}, 0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("rst_bcnt", {16'b0, o_bcnt}, 0);
`endif
        #1 rst_n = 1;
        step();
        chk("rst_release_valid", {31'b0, o_valid}, 1);
        chk("rst_release_rs", {27'b0, o_rs}, 6);
`ifdef ID_EX_BUBBLE_COUNT_EN
        flush = 1;
        step();
        step();
        flush = 0;
        chk("bcnt_two_flushes", {16'b0, o_bcnt}, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
